sw_store_buffer: RTL and testbench

Data-side memory stage placed directly downstream of the SW single-cycle processor. It accepts store requests (address from the ALU result, data from the second register read port), holds them in a small in-order write buffer, and drains them one per cycle into an internal single-port word RAM. Loads are serviced with youngest-match forwarding from the buffer, so program order is preserved without stalling the processor on every store.

---
 rtl/sw_store_buffer_if.sv | 30 +++
 rtl/sw_store_buffer.sv | 120 ++++++++++++
 tb/tb_sw_store_buffer.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/sw_store_buffer_if.sv
// Processor-to-store-buffer bus: store request, load request/response, occupancy.
// Ports: st_valid/st_addr/st_data/st_ready (store), ld_valid/ld_addr/ld_data/ld_done (load),
//        count/empty (occupancy). master = processor side, slave = store buffer side.
interface sw_store_buffer_if #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 16
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              st_valid;
  logic [15:0]       st_addr;
  logic [DATA_W-1:0] st_data;
  logic              st_ready;
  logic              ld_valid;
  logic [15:0]       ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_done;
  logic [CNT_W-1:0]  count;
  logic              empty;

  modport master (
    output st_valid, st_addr, st_data, ld_valid, ld_addr,
    input  st_ready, ld_data, ld_done, count, empty
  );

  modport slave (
    input  st_valid, st_addr, st_data, ld_valid, ld_addr,
    output st_ready, ld_data, ld_done, count, empty
  );
endinterface

// File: rtl/sw_store_buffer.sv
// In-order write buffer in front of a single-port word RAM, with youngest-match load forwarding.
// Latency: store visible to loads the cycle after accept; load data registered, 1 cycle.
// Backpressure: st_ready drops when all DEPTH entries are occupied; loads are never stalled
// and own the RAM port, so any load cycle blocks draining.
// Ports: clk_i, reset_i (sync, active-high), bus (slave modport of sw_store_buffer_if).
module sw_store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic           clk_i,
  input  logic           reset_i,
  sw_store_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  // Buffer entries; head_q is the oldest, tail_q the next free slot.
  logic [ADDR_W-1:0] ent_addr_q [DEPTH];
  logic [DATA_W-1:0] ent_data_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [DATA_W-1:0] ram_q [2**ADDR_W];

  logic [DATA_W-1:0] ld_data_q, ld_data_d;
  logic              ld_done_q, ld_done_d;

  logic              st_acc;
  logic              drain;
  logic [ADDR_W-1:0] st_a;
  logic [ADDR_W-1:0] ld_a;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  // Upper address bits are deliberately ignored, so aliasing addresses compare equal.
  logic              unused_upper;
  assign unused_upper = ^{bus.st_addr[15:ADDR_W], bus.ld_addr[15:ADDR_W]};

  assign st_a = bus.st_addr[ADDR_W-1:0];
  assign ld_a = bus.ld_addr[ADDR_W-1:0];

  // st_ready looks only at the registered count: a drain in the same cycle does not
  // free a slot early, which keeps the ready path free of the ld_valid input.
  assign st_acc = bus.st_valid && (count_q != FULL);
  assign drain  = (count_q != '0) && !bus.ld_valid;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (drain)  head_d = head_q + PTR_W'(1);
    if (st_acc) tail_d = tail_q + PTR_W'(1);
    case ({st_acc, drain})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Walk occupied entries oldest to youngest; the last match wins, giving youngest-match
  // forwarding. A store accepted this same cycle is not yet in the array, so the load
  // sees the prior value.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < count_q) && (ent_addr_q[head_q + PTR_W'(i)] == ld_a)) begin
        fwd_hit  = 1'b1;
        fwd_data = ent_data_q[head_q + PTR_W'(i)];
      end
    end
  end

  // A load cycle never drains, so the RAM sees either one read or one write per cycle.
  always_comb begin
    ld_done_d = bus.ld_valid;
    ld_data_d = fwd_hit ? fwd_data : ram_q[ld_a];
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      ld_done_q <= 1'b0;
      ld_data_q <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      ld_done_q <= ld_done_d;
      // ld_data holds its last value between loads.
      if (bus.ld_valid) ld_data_q <= ld_data_d;
    end
  end

  // Entry payload needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clk_i) begin
    if (!reset_i && st_acc) begin
      ent_addr_q[tail_q] <= st_a;
      ent_data_q[tail_q] <= bus.st_data;
    end
  end

  // RAM is never cleared; a drain coinciding with reset is discarded with the buffer.
  always_ff @(posedge clk_i) begin
    if (!reset_i && drain) begin
      ram_q[ent_addr_q[head_q]] <= ent_data_q[head_q];
    end
  end

  assign bus.st_ready = (count_q != FULL);
  assign bus.count    = count_q;
  assign bus.empty    = (count_q == '0);
  assign bus.ld_data  = ld_data_q;
  assign bus.ld_done  = ld_done_q;
endmodule

// File: tb/tb_sw_store_buffer.sv
module tb_sw_store_buffer;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sw_store_buffer_if #(.DEPTH(DEPTH), .DATA_W(DATA_W)) bus ();

  sw_store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: pending stores in program order plus a flat memory image.
  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } ent_t;
  ent_t pend[$];
  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Scoreboard of expected load responses, tagged with the cycle they are due.
  typedef struct {
    int                due;
    logic [DATA_W-1:0] d;
  } exp_t;
  exp_t expq[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit                mon_on = 1'b0;
  bit                rst_seen = 1'b1;
  logic [DATA_W-1:0] last_ld = '0;

  // Newest pending store to the address wins, otherwise memory.
  function automatic logic [DATA_W-1:0] model_load(input logic [ADDR_W-1:0] a);
    for (int i = pend.size() - 1; i >= 0; i--)
      if (pend[i].a == a) return pend[i].d;
    return mem[a];
  endfunction

  // One clock cycle of stimulus; the model advances with the edge.
  task automatic step(input bit stv, input logic [15:0] sta, input logic [15:0] std,
                      input bit ldv, input logic [15:0] lda, input bit rst);
    bit rdy;
    reset        = rst;
    bus.st_valid = stv;
    bus.st_addr  = sta;
    bus.st_data  = std;
    bus.ld_valid = ldv;
    bus.ld_addr  = lda;
    if (mon_on) begin
      chk("count", 32'(bus.count), 32'(pend.size()));
      chk("empty", 32'(bus.empty), 32'(pend.size() == 0));
      chk("st_ready", 32'(bus.st_ready), 32'(pend.size() != DEPTH));
    end
    rdy = (pend.size() != DEPTH);
    if (ldv && !rst) begin
      exp_t e;
      e.due = cyc + 1;
      e.d   = model_load(lda[ADDR_W-1:0]);
      expq.push_back(e);
    end
    @(posedge clk);
    #1;
    rst_seen = rst;
    mon_on   = 1'b1;
    if (rst) begin
      pend.delete();
    end else begin
      if (!ldv && pend.size() > 0) begin
        ent_t h;
        h = pend.pop_front();
        mem[h.a] = h.d;
      end
      if (stv && rdy) begin
        ent_t n;
        n.a = sta[ADDR_W-1:0];
        n.d = std;
        pend.push_back(n);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic st(input logic [15:0] a, input logic [15:0] d);
    step(1'b1, a, d, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic ld(input logic [15:0] a);
    step(1'b0, 16'h0, 16'h0, 1'b1, a, 1'b0);
  endtask

  // Monitor: checks every cycle's load response against the scoreboard.
  always @(negedge clk) begin
    if (mon_on) begin
      if (rst_seen) begin
        chk("rst_ld_done", 32'(bus.ld_done), 32'h0);
        chk("rst_ld_data", 32'(bus.ld_data), 32'h0);
        last_ld = '0;
      end else if (expq.size() > 0 && expq[0].due == cyc) begin
        exp_t e;
        e = expq.pop_front();
        chk("ld_done", 32'(bus.ld_done), 32'h1);
        chk("ld_data", 32'(bus.ld_data), 32'(e.d));
        last_ld = e.d;
      end else begin
        chk("ld_done_idle", 32'(bus.ld_done), 32'h0);
        chk("ld_data_hold", 32'(bus.ld_data), 32'(last_ld));
      end
    end
  end

  initial begin
    bus.st_valid = 1'b0;
    bus.st_addr  = '0;
    bus.st_data  = '0;
    bus.ld_valid = 1'b0;
    bus.ld_addr  = '0;

    // Reset then idle.
    step(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b1);
    step(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b1);
    idle(2);

    // Give every RAM word a known value so all later loads are predictable.
    for (int i = 0; i < 2**ADDR_W; i++) st(16'(i), 16'($urandom_range(0, 65535)));
    idle(3);

    // Single store: count 1 then 0.
    st(16'h0040, 16'h4242);
    idle(2);

    // Youngest-match forwarding with loads blocking drain.
    st(16'h0010, 16'hAAAA);
    step(1'b1, 16'h0010, 16'hBBBB, 1'b1, 16'h0010, 1'b0);
    for (int i = 0; i < 3; i++) ld(16'h0010);
    idle(3);

    // Fill to capacity while loads hold off draining; fifth store must be refused.
    for (int i = 0; i < 5; i++)
      step(1'b1, 16'(16'h0060 + i), 16'(16'hD000 + i), 1'b1, 16'h0080, 1'b0);
    idle(4);
    for (int i = 0; i < 5; i++) ld(16'(16'h0060 + i));
    idle(2);

    // Pointer wrap-around.
    for (int i = 0; i < 10; i++) begin
      st(16'(i), 16'(16'h0100 + i));
      idle(1);
    end
    for (int i = 0; i < 10; i++) ld(16'(i));
    idle(2);

    // Same-cycle store and load to one address.
    st(16'h0003, 16'h1234);
    idle(2);
    step(1'b1, 16'h0003, 16'h5678, 1'b1, 16'h0003, 1'b0);
    ld(16'h0003);
    idle(3);
    ld(16'h0003);
    idle(1);

    // Reset with three entries buffered; a load in the reset cycle gets no response.
    step(1'b1, 16'h0020, 16'h1111, 1'b1, 16'h0090, 1'b0);
    step(1'b1, 16'h0021, 16'h2222, 1'b1, 16'h0090, 1'b0);
    step(1'b1, 16'h0022, 16'h3333, 1'b1, 16'h0090, 1'b0);
    step(1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0020, 1'b1);
    ld(16'h0020);
    ld(16'h0021);
    idle(2);

    // Upper address bits alias.
    st(16'h0105, 16'hC0DE);
    ld(16'h0005);
    idle(2);
    ld(16'hFF05);
    idle(1);

    // Randomized traffic over a small address window with aliasing upper bits.
    for (int i = 0; i < 400; i++) begin
      bit          stv;
      bit          ldv;
      bit          rst;
      logic [15:0] sa;
      logic [15:0] la;
      stv = ($urandom_range(0, 99) < 60);
      ldv = ($urandom_range(0, 99) < 50);
      rst = ($urandom_range(0, 99) == 0);
      sa  = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 15))};
      la  = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 15))};
      step(stv, sa, 16'($urandom_range(0, 65535)), ldv, la, rst);
    end
    idle(6);
    for (int i = 0; i < 16; i++) ld(16'(i));
    idle(3);

    chk("pending_responses", 32'(expq.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
